// File: rtl/riscv_imem_loader_if.sv
// Byte-stream channel feeding the instruction-memory loader.
// The master drives bytes; the loader (slave) answers with a registered ready.
interface riscv_imem_loader_if;
  logic       s_valid;
  logic       s_ready;
  logic [7:0] s_data;
  logic       s_last;

  modport master (output s_valid, output s_data, output s_last, input s_ready);
  modport slave  (input s_valid, input s_data, input s_last, output s_ready);
endinterface

// File: rtl/riscv_imem_loader.sv
// Boot loader: packs a byte stream little-endian into 32-bit words, writes them
// to instruction memory from word 0 upward, then releases the core after a delay.
module riscv_imem_loader #(
  parameter int ADDR_W        = 8,
  parameter int RELEASE_DELAY = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  riscv_imem_loader_if.slave   s,
  output logic                 imem_we,
  output logic [ADDR_W-1:0]    imem_addr,
  output logic [31:0]          imem_wdata,
  output logic                 core_reset,
  output logic                 done,
  output logic                 error,
  output logic [ADDR_W:0]      words_loaded
);

  typedef enum logic [1:0] {LOAD, DELAY, RUN, ERROR} state_t;

  localparam logic [7:0] CNT_LAST = 8'(RELEASE_DELAY - 1);

  state_t          state_q, state_d;
  logic            s_ready_q;
  logic [1:0]      idx_q;
  logic [31:0]     asm_q;
  logic [ADDR_W:0] wp_q;
  logic [7:0]      cnt_q;

  logic            accept, full, store, complete;
  logic [31:0]     word_d;

  assign s.s_ready = s_ready_q;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    accept   = s.s_valid && s_ready_q;
    // wp carries one extra bit so "memory full" is distinguishable from address 0.
    full     = wp_q[ADDR_W];
    store    = accept && !full;
    complete = store && ((idx_q == 2'd3) || s.s_last);
    word_d   = asm_q;
    word_d[8*idx_q +: 8] = s.s_data;

    state_d = state_q;
    unique case (state_q)
      LOAD: begin
        if (accept && full)           state_d = ERROR;
        else if (store && s.s_last)   state_d = DELAY;
      end
      DELAY: begin
        if (cnt_q == CNT_LAST)        state_d = RUN;
      end
      default: state_d = state_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= LOAD;
      s_ready_q    <= 1'b1;
      imem_we      <= 1'b0;
      imem_addr    <= '0;
      imem_wdata   <= '0;
      core_reset   <= 1'b1;
      done         <= 1'b0;
      error        <= 1'b0;
      words_loaded <= '0;
      idx_q        <= '0;
      asm_q        <= '0;
      wp_q         <= '0;
      cnt_q        <= '0;
    end else begin
      state_q    <= state_d;
      s_ready_q  <= (state_d == LOAD);
      core_reset <= (state_d != RUN);
      done       <= (state_d == RUN);
      error      <= (state_d == ERROR);
      imem_we    <= complete;

      if (complete) begin
        imem_addr  <= wp_q[ADDR_W-1:0];
        imem_wdata <= word_d;
        wp_q       <= wp_q + 1'b1;
        asm_q      <= '0;
        idx_q      <= '0;
      end else if (store) begin
        asm_q <= word_d;
        idx_q <= idx_q + 2'd1;
      end

      // The count trails the strobe by one cycle.
      if (imem_we) words_loaded <= words_loaded + 1'b1;

      cnt_q <= (state_q == DELAY) ? cnt_q + 8'd1 : 8'd0;
    end
  end

endmodule

// File: tb/tb_riscv_imem_loader.sv
// Directed bench for riscv_imem_loader: a wide instance (ADDR_W=8) for the main
// load scenarios and a tiny one (ADDR_W=2) for the capacity boundary.
module tb_riscv_imem_loader;

  localparam int RD = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  // Shared stimulus steered to one of the two loaders by sel.
  logic       v, l, sel;
  logic [7:0] d;
  logic       rdy;

  riscv_imem_loader_if bus_a ();
  riscv_imem_loader_if bus_b ();

  assign bus_a.s_valid = v && !sel;
  assign bus_a.s_data  = d;
  assign bus_a.s_last  = l;
  assign bus_b.s_valid = v && sel;
  assign bus_b.s_data  = d;
  assign bus_b.s_last  = l;
  assign rdy = sel ? bus_b.s_ready : bus_a.s_ready;

  logic        we_a, cr_a, done_a, err_a;
  logic [7:0]  addr_a;
  logic [31:0] wdata_a;
  logic [8:0]  wl_a;

  logic        we_b, cr_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wdata_b;
  logic [2:0]  wl_b;

  riscv_imem_loader #(.ADDR_W(8), .RELEASE_DELAY(RD)) dut_a (
    .clk(clk), .reset(reset), .s(bus_a.slave),
    .imem_we(we_a), .imem_addr(addr_a), .imem_wdata(wdata_a),
    .core_reset(cr_a), .done(done_a), .error(err_a), .words_loaded(wl_a)
  );

  riscv_imem_loader #(.ADDR_W(2), .RELEASE_DELAY(RD)) dut_b (
    .clk(clk), .reset(reset), .s(bus_b.slave),
    .imem_we(we_b), .imem_addr(addr_b), .imem_wdata(wdata_b),
    .core_reset(cr_b), .done(done_b), .error(err_b), .words_loaded(wl_b)
  );

  // Write log per instance, sampled mid-cycle.
  logic [31:0] qa_addr[$], qa_data[$], qb_addr[$], qb_data[$];
  always @(negedge clk) begin
    if (we_a) begin qa_addr.push_back(32'(addr_a)); qa_data.push_back(wdata_a); end
    if (we_b) begin qb_addr.push_back(32'(addr_b)); qb_data.push_back(wdata_b); end
  end

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    v = 1'b0; l = 1'b0; d = 8'h00; reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    qa_addr.delete(); qa_data.delete(); qb_addr.delete(); qb_data.delete();
  endtask

  // Present one byte and return 1ns after the edge that accepted it.
  task automatic send(input logic [7:0] b, input logic lst);
    int n = 0;
    v = 1'b1; d = b; l = lst;
    @(negedge clk);
    while (!rdy && n < 50) begin n++; @(negedge clk); end
    if (!rdy) begin
      total++; bad++;
      $error("FAIL send_timeout: observed=ready_low expected=ready_high");
    end
    @(posedge clk); #1;
    v = 1'b0; l = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  logic [31:0] exp9 [3]  = '{32'h04030201, 32'h08070605, 32'h00000009};
  logic [31:0] exp16[4]  = '{32'h13121110, 32'h17161514, 32'h1B1A1918, 32'h1F1E1D1C};

  initial begin
    sel = 1'b0;
    do_reset();

    // Reset state.
    check("rst_ready", bus_a.s_ready, 1);
    check("rst_we",    we_a, 0);
    check("rst_addr",  addr_a, 0);
    check("rst_wdata", wdata_a, 0);
    check("rst_core",  cr_a, 1);
    check("rst_done",  done_a, 0);
    check("rst_err",   err_a, 0);
    check("rst_wl",    wl_a, 0);

    // Single word program and release timing.
    send(8'h13, 0); send(8'h05, 0); send(8'h50, 0); send(8'h00, 1);
    check("t1_we",    we_a, 1);
    check("t1_addr",  addr_a, 0);
    check("t1_wdata", wdata_a, 32'h00500513);
    check("t1_ready", bus_a.s_ready, 0);
    cycles(1);
    check("t1_we_one_cycle", we_a, 0);
    check("t1_wl", wl_a, 1);
    cycles(RD - 2);
    check("t1_core_held", cr_a, 1);
    check("t1_not_done",  done_a, 0);
    cycles(1);
    check("t1_core_rel", cr_a, 0);
    check("t1_done",     done_a, 1);
    check("t1_nwrites",  qa_addr.size(), 1);

    // Nine bytes, back to back.
    do_reset();
    for (int i = 1; i <= 9; i++) send(8'(i), i == 9);
    cycles(RD + 2);
    check("t2_nwrites", qa_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t2_addr%0d", i), qa_addr[i], i);
      check($sformatf("t2_data%0d", i), qa_data[i], exp9[i]);
    end
    check("t2_wl",   wl_a, 3);
    check("t2_done", done_a, 1);

    // Nine bytes with valid toggling every cycle.
    do_reset();
    for (int i = 1; i <= 9; i++) begin
      send(8'(i), i == 9);
      if (i != 9) begin
        @(negedge clk);
        check($sformatf("t3_ready_stall%0d", i), bus_a.s_ready, 1);
        @(posedge clk); #1;
      end
    end
    cycles(RD + 2);
    check("t3_nwrites", qa_addr.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t3_addr%0d", i), qa_addr[i], i);
      check($sformatf("t3_data%0d", i), qa_data[i], exp9[i]);
    end
    check("t3_core", cr_a, 0);

    // RUN ignores the stream.
    for (int i = 0; i < 20; i++) begin
      v = 1'b1; d = 8'($urandom); l = 1'($urandom);
      @(negedge clk);
      check("run_ready", bus_a.s_ready, 0);
      check("run_we",    we_a, 0);
      check("run_core",  cr_a, 0);
      @(posedge clk); #1;
    end
    v = 1'b0;
    check("run_wl", wl_a, 3);

    // Reset mid-load discards the partial word.
    do_reset();
    for (int i = 1; i <= 6; i++) send(8'(i), 0);
    do_reset();
    send(8'hAA, 0); send(8'hBB, 0); send(8'hCC, 0); send(8'hDD, 1);
    cycles(RD + 2);
    check("t5_nwrites", qa_addr.size(), 1);
    check("t5_addr",    qa_addr[0], 0);
    check("t5_data",    qa_data[0], 32'hDDCCBBAA);
    check("t5_wl",      wl_a, 1);

    // Small memory: exactly full is legal.
    sel = 1'b1;
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), i == 15);
    cycles(RD + 2);
    check("t4_nwrites", qb_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t4_addr%0d", i), qb_addr[i], i);
      check($sformatf("t4_data%0d", i), qb_data[i], exp16[i]);
    end
    check("t4_err",  err_b, 0);
    check("t4_done", done_b, 1);
    check("t4_wl",   wl_b, 4);

    // Small memory: one byte too many.
    do_reset();
    for (int i = 0; i < 16; i++) send(8'(8'h10 + i), 0);
    check("t4o_err_before", err_b, 0);
    send(8'h20, 1);
    check("t4o_err",   err_b, 1);
    check("t4o_ready", bus_b.s_ready, 0);
    check("t4o_core",  cr_b, 1);
    check("t4o_we",    we_b, 0);
    cycles(RD + 4);
    check("t4o_nwrites", qb_addr.size(), 4);
    check("t4o_core_held", cr_b, 1);
    check("t4o_not_done",  done_b, 0);
    check("t4o_err_sticky", err_b, 1);
    check("t4o_wl", wl_b, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/riscv_imem_loader.md
Name: riscv_imem_loader

Overview:
- Boot-time program loader upstream of riscv_single_top.
- Holds the core in reset and accepts a byte stream over a valid/ready handshake.
- Packs the bytes little-endian into 32-bit words, writes them to instruction memory at word addresses 0, 1, 2, …, then releases the core after a fixed delay.
- Lets benches and boards load programs without $readmemh and without a hand-timed reset pulse.

Parameters:
- ADDR_W, 8: instruction memory word-address width; capacity is 2^ADDR_W words.
- RELEASE_DELAY, 4: cycles spent in DELAY before core_reset deasserts; legal range 1..255.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- s_valid  in  1  byte-stream valid.
- s_ready  out  1  byte-stream ready.
- s_data  in  8  program byte.
- s_last  in  1  qualified by s_valid; marks the final byte of the program.
- imem_we  out  1  single-cycle instruction-memory write strobe.
- imem_addr  out  ADDR_W  word address of the write.
- imem_wdata  out  32  word to write.
- core_reset  out  1  active-high reset to riscv_single_top.
- done  out  1  high once the core is released.
- error  out  1  sticky overflow flag.
- words_loaded  out  ADDR_W+1  count of words written so far.

Behaviour:
- Reset values (reset high at an edge): state=LOAD; s_ready=1; imem_we=0; imem_addr=0; imem_wdata=0; core_reset=1; done=0; error=0; words_loaded=0; byte index=0; write pointer wp=0.
- Reset mid-operation: same values; any partially assembled word is discarded.
- Handshake: a byte is accepted when s_valid && s_ready at a rising edge. s_ready is a registered output, 1 only in LOAD. s_data and s_last are ignored when the byte is not accepted.
- Byte packing: the byte with index k (0..3) goes to bits [8k+7:8k]. The index increments per accepted byte and wraps 3→0.
- Word completion: occurs at the edge accepting byte index 3, or at the edge accepting any byte with s_last=1.
  - Unfilled upper bytes are zero.
  - Registered outputs take effect the next cycle: imem_we=1 for exactly one cycle; imem_addr=wp (pre-increment value); imem_wdata=assembled word.
  - At that same edge wp increments and the assembly register clears.
  - words_loaded increments in the cycle imem_we is high, so the count is visible one cycle after the strobe.
- States:
  - LOAD→DELAY at the edge accepting s_last; s_ready drops to 0 in the same next cycle.
  - DELAY counts RELEASE_DELAY cycles, then →RUN. If s_last is accepted at edge t, the write occurs in cycle t+1 and core_reset=0, done=1 from cycle t+1+RELEASE_DELAY.
  - RUN is terminal until reset. s_ready=0 and all inputs are ignored.
  - LOAD→ERROR if a byte is accepted while wp == 2^ADDR_W (memory full). That byte is dropped and no write occurs.
  - ERROR is terminal until reset: error=1, s_ready=0, core_reset=1, done=0, imem_we=0.
- Exactly 2^ADDR_W words with s_last on the final byte is legal, with no error.
- Stall tolerance: s_valid may drop between any bytes. Assembly state holds indefinitely.
- imem_we never asserts outside the cycle after a word completion. No two writes target the same address between resets.

Test Plan:
- Four bytes 0x13,0x05,0x50,0x00 (s_last on the 4th) → one write addr 0, data 0x00500513. core_reset falls 1+RELEASE_DELAY cycles after the last accept. done=1, words_loaded=1.
- Nine bytes 0x01..0x09, s_last on 0x09 → writes addr0=0x04030201, addr1=0x08070605, addr2=0x00000009. words_loaded=3.
- Same nine bytes with s_valid toggling 1/0 every cycle → identical writes. s_ready=1 throughout LOAD.
- ADDR_W=2: 16 bytes (s_last on the 16th) → 4 writes, no error. Repeat with 17 bytes → error=1 after the 17th accept, exactly 4 writes, core_reset stays 1, s_ready=0.
- Reset asserted after 6 bytes of a load, then reload 4 bytes 0xAA,0xBB,0xCC,0xDD (s_last on 0xDD) → single write addr 0, data 0xDDCCBBAA. No stale bytes.
- In RUN, drive s_valid=1 with random data for 20 cycles → s_ready=0, no imem_we, core_reset stays 0.
